// File: rtl/ram_port_master_pkg.sv
// ram_port_master_pkg
//   Shared definitions for the RAM port-0 initiator and the instruction/data
//   RAM it drives: default bus geometry and the initiator state encoding.
package ram_port_master_pkg;

    localparam int DEF_DATA_WIDTH = 32;  // RAM word width
    localparam int DEF_ADDR_WIDTH = 6;   // RAM address width (64 words)

    // Initiator cycle states. WR is a single write strobe cycle; RD1/RD2
    // cover the RAM's registered read (address phase, then data phase);
    // RSP parks the captured word until the requester takes it.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RSP  = 3'd4
    } state_t;

endpackage : ram_port_master_pkg

// File: rtl/ram_port_master_if.sv
// ram_port_master_if
//   Bundles the request channel, the read-response channel and the RAM
//   control/address lines of one RAM port. The bidirectional RAM data bus is
//   kept outside the interface as a plain inout net on the initiator.
//
//   Signals:
//     req_valid/req_ready/req_we/req_addr/req_wdata : request channel
//     rsp_valid/rsp_ready/rsp_data                  : read response channel
//     mem_cs/mem_we/mem_oe/mem_addr                 : RAM port controls
//
//   Modports:
//     master : the initiator (consumes requests, drives the RAM port)
//     slave  : the environment (requester plus RAM)
interface ram_port_master_if #(
    parameter int DATA_WIDTH = ram_port_master_pkg::DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = ram_port_master_pkg::DEF_ADDR_WIDTH
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;

    logic                  mem_cs;
    logic                  mem_we;
    logic                  mem_oe;
    logic [ADDR_WIDTH-1:0] mem_addr;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data,
        output mem_cs, mem_we, mem_oe, mem_addr
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data,
        input  mem_cs, mem_we, mem_oe, mem_addr
    );

endinterface : ram_port_master_if

// File: rtl/ram_port_master.sv
// ram_port_master
//   Single-port initiator for port 0 of the dual-port instruction/data RAM.
//   Turns valid/ready requests into chip-select / write-enable / output-enable
//   cycles, drives the shared data bus during writes, captures the RAM's
//   registered read data and returns it on a valid/ready response channel.
//
//   Ports:
//     clk       : single clock, all state updates on the rising edge
//     rst_n     : asynchronous active-low reset
//     bus       : request, response and RAM control lines (master modport)
//     mem_data  : RAM data bus; driven only in WR, high-Z otherwise
//
//   Cycle shapes:
//     write : IDLE(accept) -> WR -> IDLE            (2 cycles per write)
//     read  : IDLE(accept) -> RD1 -> RD2 -> RSP ... (>= 4 cycles per read)
module ram_port_master
    import ram_port_master_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    ram_port_master_if.master          bus,
    inout  wire  [DATA_WIDTH-1:0]      mem_data
);

    state_t                state_q;
    state_t                state_d;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    // State and datapath registers. The request fields are sampled only on
    // the handshake edge, so req_* may wander freely while req_ready is low.
    // The direction is carried by the state itself (WR vs RD1).
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            // The RAM drives its registered word throughout RD2; this is the
            // only edge at which the response word changes.
            if (state_q == RD2) begin
                rsp_data_q <= mem_data;
            end
        end
    end

    // Next state and all control outputs decode straight from state_q, so a
    // mid-cycle reset drops the RAM controls and releases the bus at once.
    // NOTE: every signal driven here gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.mem_cs    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_oe    = 1'b0;

        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                accept        = bus.req_valid;
                if (bus.req_valid) begin
                    state_d = bus.req_we ? WR : RD1;
                end
            end
            WR: begin
                // The RAM commits on the edge leaving this state.
                bus.mem_cs = 1'b1;
                bus.mem_we = 1'b1;
                state_d    = IDLE;
            end
            RD1: begin
                // The RAM registers the addressed word on the exiting edge.
                bus.mem_cs = 1'b1;
                bus.mem_oe = 1'b1;
                state_d    = RD2;
            end
            RD2: begin
                // Controls held so the RAM keeps driving mem_data.
                bus.mem_cs = 1'b1;
                bus.mem_oe = 1'b1;
                state_d    = RSP;
            end
            RSP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The address is passed through verbatim from the captured request.
    assign bus.mem_addr = addr_q;
    assign bus.rsp_data = rsp_data_q;

    // Single tristate driver on the shared RAM data bus.
    assign mem_data = (state_q == WR) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule : ram_port_master

// File: tb/tb_ram_port_master.sv
// tb_ram_port_master
//   Self-checking bench for ram_port_master. A behavioural RAM (port 0 only,
//   port 1 left idle) sits on the initiator's bus. Directed vectors come from
//   a table; a randomized phase is checked against a plain array model of the
//   memory contents. Multi-cycle corner cases (backpressure, reset during a
//   read or write) are hand-written sequences.
module tb_ram_port_master;
    import ram_port_master_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    wire  [DW-1:0] mem_data;

    ram_port_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_port_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .mem_data (mem_data)
    );

    // Behavioural RAM port 0: synchronous write, registered read, data bus
    // driven while selected for reading. Port 1 is not exercised.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_q;

    assign mem_data = (bus.mem_cs && bus.mem_oe && !bus.mem_we) ? ram_q : {DW{1'bz}};

    always @(posedge clk) begin
        if (bus.mem_cs && bus.mem_we) ram[bus.mem_addr] <= mem_data;
        if (bus.mem_cs && bus.mem_oe && !bus.mem_we) ram_q <= ram[bus.mem_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: memory contents as seen by the requester.
    logic [DW-1:0] model_mem [DEPTH];
    bit            written   [DEPTH];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("req_ready_timeout", {31'd0, bus.req_ready}, 32'd1);
    endtask

    // Scrambles request fields after acceptance; the block must ignore them.
    task automatic idle_req();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = $urandom;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        wait_ready();
        tick();  // accept edge E0; now in the single write cycle
        idle_req();
        check("wr_ctrl {cs,we,oe,req_ready}", {28'd0, bus.mem_cs, bus.mem_we, bus.mem_oe, bus.req_ready}, 32'b1100);
        check("wr_addr", {26'd0, bus.mem_addr}, {26'd0, a});
        check("wr_bus", mem_data, d);
        model_mem[a] = d;
        written[a]   = 1'b1;
        tick();  // memory committed at E1
        check("wr_done {cs,we,req_ready}", {29'd0, bus.mem_cs, bus.mem_we, bus.req_ready}, 32'b001);
    endtask

    // Read with `hold` cycles of response backpressure; when `poke` is set
    // the requester keeps offering a write that must be ignored.
    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                           input int hold, input bit poke);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a;
        bus.req_wdata = $urandom;  // must never reach the bus on a read
        wait_ready();
        tick();  // accept E0
        idle_req();
        check("rd1 {cs,oe,we,rsp_valid,req_ready}",
              {27'd0, bus.mem_cs, bus.mem_oe, bus.mem_we, bus.rsp_valid, bus.req_ready}, 32'b11000);
        check("rd1_addr", {26'd0, bus.mem_addr}, {26'd0, a});
        tick();
        check("rd2 {cs,oe,we,rsp_valid,req_ready}",
              {27'd0, bus.mem_cs, bus.mem_oe, bus.mem_we, bus.rsp_valid, bus.req_ready}, 32'b11000);
        tick();  // 3 cycles after accept: response must be up
        check("rsp {cs,oe,we,rsp_valid,req_ready}",
              {27'd0, bus.mem_cs, bus.mem_oe, bus.mem_we, bus.rsp_valid, bus.req_ready}, 32'b00010);
        check("rsp_data", bus.rsp_data, exp);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b1;
                bus.req_addr  = a;
                bus.req_wdata = ~exp;
            end
            tick();
            check("hold {cs,rsp_valid,req_ready}", {29'd0, bus.mem_cs, bus.rsp_valid, bus.req_ready}, 32'b010);
            check("hold_rsp_data", bus.rsp_data, exp);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("rsp_done {rsp_valid,req_ready}", {30'd0, bus.rsp_valid, bus.req_ready}, 32'b01);
        check("rsp_data_held", bus.rsp_data, exp);
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;  // write data, or expected read data
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 6'd5,  32'hDEADBEEF};
        vecs[1] = '{1'b0, 6'd5,  32'hDEADBEEF};
        vecs[2] = '{1'b1, 6'd0,  32'h00000011};
        vecs[3] = '{1'b1, 6'd1,  32'h00000022};
        vecs[4] = '{1'b1, 6'd63, 32'h00000033};
        vecs[5] = '{1'b0, 6'd0,  32'h00000011};
        vecs[6] = '{1'b0, 6'd1,  32'h00000022};
        vecs[7] = '{1'b0, 6'd63, 32'h00000033};

        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = '0;
            written[i]   = 1'b0;
        end

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst {req_ready,rsp_valid,cs,we,oe}",
              {27'd0, bus.req_ready, bus.rsp_valid, bus.mem_cs, bus.mem_we, bus.mem_oe}, 32'b10000);
        check("rst_mem_addr", {26'd0, bus.mem_addr}, 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        rst_n = 1'b1;

        // Idle after reset with no requests.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle {req_ready,rsp_valid,cs}", {29'd0, bus.req_ready, bus.rsp_valid, bus.mem_cs}, 32'b100);
        end

        // Directed table: write/readback, back-to-back writes incl. top address.
        foreach (vecs[i]) begin
            if (vecs[i].we) do_write(vecs[i].addr, vecs[i].data);
            else            do_read(vecs[i].addr, vecs[i].data, 0, 1'b0);
        end

        // Response backpressure with ignored write pulses, then confirm the
        // memory was not touched.
        do_read(6'd5, 32'hDEADBEEF, 7, 1'b1);
        do_read(6'd5, model_mem[5], 0, 1'b0);

        // Randomized traffic against the array model.
        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            bit            wr;
            a  = AW'($urandom_range(0, DEPTH - 1));
            d  = $urandom;
            wr = ($urandom_range(0, 1) == 1) || !written[a];
            if (wr) do_write(a, d);
            else    do_read(a, model_mem[a], $urandom_range(0, 3), 1'($urandom));
        end

        // Reset during RD2: controls drop within the cycle, response lost.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 6'd5;
        wait_ready();
        tick();  // accept
        idle_req();
        tick();  // now in RD2
        check("pre_rst_rd2 {cs,oe}", {30'd0, bus.mem_cs, bus.mem_oe}, 32'b11);
        #2 rst_n = 1'b0;
        #1;
        check("rst_rd2 {cs,oe,rsp_valid,req_ready}",
              {28'd0, bus.mem_cs, bus.mem_oe, bus.rsp_valid, bus.req_ready}, 32'b0001);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_rd2 {rsp_valid,req_ready}", {30'd0, bus.rsp_valid, bus.req_ready}, 32'b01);
        check("post_rst_rd2_rsp_data", bus.rsp_data, 32'd0);
        do_read(6'd5, model_mem[5], 0, 1'b0);

        // Reset during WR before its commit edge: the old word survives.
        do_write(6'd7, 32'hAAAA5555);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 6'd7;
        bus.req_wdata = 32'h12345678;
        wait_ready();
        tick();  // accept; now in WR
        idle_req();
        check("pre_rst_wr {cs,we}", {30'd0, bus.mem_cs, bus.mem_we}, 32'b11);
        #2 rst_n = 1'b0;
        #1;
        check("rst_wr {cs,we}", {30'd0, bus.mem_cs, bus.mem_we}, 32'b00);
        tick();
        rst_n = 1'b1;
        tick();
        do_read(6'd7, 32'hAAAA5555, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ram_port_master
